// File: rtl/hilo_muldiv_pkg.sv
// Purpose : shared types and constants for the HI/LO multiply/divide unit.
// Latency : n/a (types only).
// Backpressure: n/a.
package muldiv_pkg;

   // Operation encoding as presented on the op bus.
   typedef enum logic [1:0] {
      MULTU = 2'b00,
      MULT  = 2'b01,
      DIVU  = 2'b10,
      DIV   = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } muldiv_state_t;

   // One iteration per operand bit.
   localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/hilo_muldiv_if.sv
// Purpose : controller <-> multiply/divide unit bundle (request, MTHI/MTLO, status, HI/LO).
// Latency : n/a (wires only).
// Backpressure: busy=1 tells the master that start/mthi/mtlo are ignored.
// Ports   : start/op/a/b request, mthi/mtlo/wdata direct writes,
//           busy/done/div_by_zero status, hi/lo register values.
interface hilo_muldiv_if #(
   parameter int n = 32
);
   logic         start;
   logic [1:0]   op;
   logic [n-1:0] a;
   logic [n-1:0] b;
   logic         mthi;
   logic         mtlo;
   logic [n-1:0] wdata;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [n-1:0] hi;
   logic [n-1:0] lo;

   modport master (
      output start, op, a, b, mthi, mtlo, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, mthi, mtlo, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv_signfix.sv
// Purpose : conditional two's-complement negate (magnitude <-> signed conversion).
// Latency : combinational.
// Backpressure: none.
// Ports   : val_i value, neg_i negate when high, res_o result.
module muldiv_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_o
);
   assign res_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/hilo_muldiv.sv
// Purpose : iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO register pair.
// Latency : start sampled at E0, done pulses after edge E(n+1) with hi/lo valid.
// Backpressure: busy=1 from E0 to E(n+1); start/mthi/mtlo ignored while busy.
// Ports   : clk, rst (async active-low), bus (slave side of hilo_muldiv_if).
module hilo_muldiv
   import muldiv_pkg::*;
#(
   parameter int n = MULDIV_ITERS
) (
   input  logic        clk,
   input  logic        rst,
   hilo_muldiv_if.slave bus
);
   localparam int CW = $clog2(n);

   muldiv_state_t   state_q, state_d;
   logic [2*n-1:0]  acc_q, acc_d;      // multiply: {partial, multiplier}; divide: {rem, quot}
   logic [n-1:0]    opnd_q, opnd_d;    // |multiplicand| or |divisor|
   logic [n-1:0]    a_raw_q, a_raw_d;  // unmodified dividend, returned in HI on divide by zero
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            is_div_q, is_div_d;
   logic            neg_res_q, neg_res_d; // signed op with differing operand signs
   logic            neg_rem_q, neg_rem_d; // signed op with negative dividend
   logic            bzero_q, bzero_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            dbz_q, dbz_d;
   logic [n-1:0]    hi_q, hi_d;
   logic [n-1:0]    lo_q, lo_d;

   logic            op_signed, op_div;
   logic [n-1:0]    a_abs, b_abs;
   logic [2*n-1:0]  prod_fix;
   logic [n-1:0]    quot_fix, rem_fix;
   logic [n:0]      add_sum, rem_sh, diff;
   logic [2*n-1:0]  mul_next, div_next;

   assign op_signed = (bus.op == MULT) || (bus.op == DIV);
   assign op_div    = (bus.op == DIVU) || (bus.op == DIV);

   muldiv_signfix #(.W(n)) u_fix_a (.val_i(bus.a), .neg_i(op_signed & bus.a[n-1]), .res_o(a_abs));
   muldiv_signfix #(.W(n)) u_fix_b (.val_i(bus.b), .neg_i(op_signed & bus.b[n-1]), .res_o(b_abs));
   muldiv_signfix #(.W(2*n)) u_fix_p (.val_i(acc_q), .neg_i(neg_res_q), .res_o(prod_fix));
   muldiv_signfix #(.W(n)) u_fix_q (.val_i(acc_q[n-1:0]), .neg_i(neg_res_q), .res_o(quot_fix));
   muldiv_signfix #(.W(n)) u_fix_r (.val_i(acc_q[2*n-1:n]), .neg_i(neg_rem_q), .res_o(rem_fix));

   // Shift-add: add the multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right by one.
   assign add_sum  = {1'b0, acc_q[2*n-1:n]} + {1'b0, opnd_q};
   assign mul_next = acc_q[0] ? {add_sum, acc_q[n-1:1]} : {1'b0, acc_q[2*n-1:1]};

   // Restoring divide: bring the next dividend bit into the remainder and
   // keep the difference only when it did not go negative.
   assign rem_sh   = {acc_q[2*n-1:n], acc_q[n-1]};
   assign diff     = rem_sh - {1'b0, opnd_q};
   assign div_next = diff[n] ? {rem_sh[n-1:0], acc_q[n-2:0], 1'b0}
                             : {diff[n-1:0],   acc_q[n-2:0], 1'b1};

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      a_raw_d   = a_raw_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      bzero_d   = bzero_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         IDLE: begin
            if (bus.mthi) hi_d = bus.wdata;
            if (bus.mtlo) lo_d = bus.wdata;
            if (bus.start) begin
               acc_d     = {{n{1'b0}}, a_abs};
               opnd_d    = b_abs;
               a_raw_d   = bus.a;
               cnt_d     = '0;
               is_div_d  = op_div;
               neg_res_d = op_signed & (bus.a[n-1] ^ bus.b[n-1]);
               neg_rem_d = op_signed & bus.a[n-1];
               bzero_d   = (bus.b == '0);
               busy_d    = 1'b1;
               dbz_d     = 1'b0;
               state_d   = CALC;
            end
         end
         CALC: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(n-1)) state_d = FIX;
         end
         FIX: begin
            if (!is_div_q) begin
               hi_d = prod_fix[2*n-1:n];
               lo_d = prod_fix[n-1:0];
            end else if (bzero_q) begin
               hi_d  = a_raw_q;
               lo_d  = {n{1'b1}};
               dbz_d = 1'b1;
            end else begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         opnd_q    <= '0;
         a_raw_q   <= '0;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         bzero_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         a_raw_q   <= a_raw_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         bzero_q   <= bzero_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule
